wm8731_config_seq: RTL and testbench
====================================

WM8731_CONFIG_SEQ -- requirements
Module: wm8731_config_seq

Interface
REQ-001 Parameter QUARTER, default 125: clk cycles per quarter I2C bit period (50 MHz clk gives 100 kHz SCLK).
REQ-002 Parameter MAX_RETRY, default 3: retries per table entry after a NACK before the block errors.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: single-cycle request to run the full configuration table.
REQ-006 Port sdat_in, input, 1: sampled level of the I2C SDAT pad.
REQ-007 Port sdat_oe, output, 1: 1 drives SDAT low; 0 releases SDAT (pull-up gives high).
REQ-008 Port sclk, output, 1: I2C SCLK, driven push-pull.
REQ-009 Port busy, output, 1: sequence in progress.
REQ-010 Port done, output, 1: sticky; all entries acknowledged.
REQ-011 Port error, output, 1: sticky; an entry exhausted its retries.
REQ-012 Port entry_idx, output, 4: index of the current or last table entry, 0-10.

Function
REQ-013 Fixed table, 11 entries, each a 16-bit word {reg[6:0], data[8:0]}, sent in this order (reg:data hex): 0F:000, 00:017, 01:017, 02:079, 03:079, 04:012, 05:000, 06:000, 07:042, 08:000, 09:001.
REQ-014 Each entry is one transaction: START; byte 0x34; ACK slot; word[15:8]; ACK slot; word[7:0]; ACK slot; STOP; GAP. Bytes are sent MSB first.
REQ-015 Bit slot is 4 quarters. q0 and q1: sclk=0, with SDA set at the start of q0. q2 and q3: sclk=1.
REQ-016 In an ACK slot sdat_oe=0, and sdat_in is sampled on the last cycle of q2; 0 means ACK, 1 means NACK.
REQ-017 START is 4 quarters with sclk=1: q0-q1 sdat_oe=0, q2-q3 sdat_oe=1.
REQ-018 STOP is 4 quarters: q0 sclk=0 with sdat_oe=1; q1-q2 sclk=1 with sdat_oe=1; q3 sclk=1 with sdat_oe=0.
REQ-019 GAP is 4 quarters with sclk=1 and sdat_oe=0.
REQ-020 Transaction length is 120 quarters (120*QUARTER cycles).
REQ-021 States: IDLE, START, BIT, ACK, STOP, GAP, DONE, ERROR.
REQ-022 From IDLE, DONE or ERROR: start=1 gives the next state START, with busy=1, done=0, error=0, entry_idx=0 and the retry count cleared.
REQ-023 start is ignored while busy=1.
REQ-024 NACK in any ACK slot: skip the remaining bytes, go to STOP then GAP, and retry the same entry while the retry count is below MAX_RETRY.
REQ-025 The retry count increments on each NACK and clears when an entry completes with all ACKs.
REQ-026 When an entry completes with all ACKs: if entry_idx<10, increment entry_idx and go to START after GAP; if entry_idx=10, go to DONE after GAP.
REQ-027 On the NACK that makes the retry count exceed MAX_RETRY: go to STOP, GAP, then ERROR. entry_idx holds the failing entry.
REQ-028 In DONE and ERROR: busy=0, sclk=1, sdat_oe=0, and the flag stays high until the next accepted start or reset.
REQ-029 Latency with all ACKs: done rises 11*120*QUARTER cycles (±2) after the start-accept edge, and busy falls on the same edge.
REQ-030 The quarter counter counts 0..QUARTER-1 and wraps; phase advances only on wrap.

Reset
REQ-031 While reset=1: sclk=1, sdat_oe=0, busy=0, done=0, error=0, entry_idx=0, state IDLE, all counters 0.
REQ-032 Reset asserted mid-transaction releases the bus immediately (asynchronously) with no STOP. A later start restarts from entry 0.

Verification (QUARTER=4, so a transaction is 480 cycles)
REQ-033 Reset, then start with an I2C slave model that ACKs all bytes. Required: 11 transactions with bytes 34,1E,00,34,00,17 ... 34,12,01 in order; done=1 at 5280±2 cycles; busy=0; error=0; entry_idx=10.
REQ-034 Slave NACKs the first address byte of entry 3 twice, then ACKs. Required: entry 3 sent 3 times, each NACK followed by STOP; done at 6240±2 cycles; error=0.
REQ-035 Slave always NACKs entry 5. Required: 4 attempts of entry 5; error=1, done=0, entry_idx=5, busy=0, sclk=1, sdat_oe=0.
REQ-036 Second start pulse during entry 2. Required: ignored; sequence and timing identical to REQ-033.
REQ-037 Reset asserted in the data byte of entry 4. Required: the same cycle shows sclk=1 and sdat_oe=0, with all flags 0. A subsequent start restarts from entry 0 and completes.
REQ-038 Protocol monitor on all runs. Required: SDA changes only while sclk=0, except at START/STOP; every byte is followed by an ACK slot with sdat_oe=0.

Source files
------------

// File: rtl/wm8731_config_seq.sv
// Power-up configuration sequencer for the WM8731 codec: streams a fixed
// 11-entry register table over I2C, retrying NACKed entries a bounded number of times.
module wm8731_config_seq #(
  parameter int QUARTER   = 125,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sdat_in,
  output logic       sdat_oe,
  output logic       sclk,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] entry_idx
);

  localparam int QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [QW-1:0] Q_LAST   = QW'(QUARTER - 1);
  localparam logic [6:0]    TXN_LAST = 7'd119;
  localparam logic [7:0]    DEV_ADDR = 8'h34;

  typedef enum logic [2:0] {
    IDLE, START, BIT, ACK, STOP, GAP, DONE, ERROR
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [6:0]    txn_q;
  logic [RW-1:0] retry_cnt;
  logic          nack_seen;
  logic          nacked;
  logic          give_up;

  logic [15:0]   word;
  logic [7:0]    cur_byte;
  logic          cur_bit;
  logic          wrap;

  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {7'h0F, 9'h000};
      4'd1:    w = {7'h00, 9'h017};
      4'd2:    w = {7'h01, 9'h017};
      4'd3:    w = {7'h02, 9'h079};
      4'd4:    w = {7'h03, 9'h079};
      4'd5:    w = {7'h04, 9'h012};
      4'd6:    w = {7'h05, 9'h000};
      4'd7:    w = {7'h06, 9'h000};
      4'd8:    w = {7'h07, 9'h042};
      4'd9:    w = {7'h08, 9'h000};
      4'd10:   w = {7'h09, 9'h001};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Bus levels {sclk, sdat_oe} for each state and quarter of the slot.
  function automatic logic [1:0] bus_level(input state_t s, input logic [1:0] ph, input logic b);
    logic [1:0] lv;
    case (s)
      START:   lv = {1'b1, ph[1]};
      BIT:     lv = {ph[1], ~b};
      ACK:     lv = {ph[1], 1'b0};
      STOP:    lv = {ph != 2'd0, ph != 2'd3};
      default: lv = 2'b10;
    endcase
    return lv;
  endfunction

  always_comb begin
    word = table_word(entry_idx);
    case (byte_idx)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
    cur_bit = cur_byte[bit_idx];
  end

  assign wrap = (qcnt == Q_LAST);

  // Bus outputs trail the state by one clock; SCLK and SDA move together so
  // their relative timing is exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sclk      <= 1'b1;
      sdat_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      entry_idx <= 4'd0;
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_idx   <= 3'd7;
      byte_idx  <= 2'd0;
      txn_q     <= 7'd0;
      retry_cnt <= '0;
      nack_seen <= 1'b0;
      nacked    <= 1'b0;
      give_up   <= 1'b0;
    end else begin
      {sclk, sdat_oe} <= bus_level(state, phase, cur_bit);
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= START;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            entry_idx <= 4'd0;
            retry_cnt <= '0;
            qcnt      <= '0;
            phase     <= 2'd0;
            txn_q     <= 7'd0;
            nacked    <= 1'b0;
            give_up   <= 1'b0;
          end
        end
        default: begin
          qcnt <= wrap ? '0 : qcnt + 1'b1;
          if (state == ACK && phase == 2'd2 && wrap)
            nack_seen <= sdat_in;
          if (wrap) begin
            phase <= phase + 1'b1;
            txn_q <= txn_q + 1'b1;
            case (state)
              START: if (phase == 2'd3) begin
                state    <= BIT;
                byte_idx <= 2'd0;
                bit_idx  <= 3'd7;
              end
              BIT: if (phase == 2'd3) begin
                if (bit_idx == 3'd0) state <= ACK;
                else bit_idx <= bit_idx - 1'b1;
              end
              ACK: if (phase == 2'd3) begin
                if (nack_seen) begin
                  nacked    <= 1'b1;
                  retry_cnt <= retry_cnt + 1'b1;
                  give_up   <= (retry_cnt >= RW'(MAX_RETRY));
                  state     <= STOP;
                end else if (byte_idx == 2'd2) begin
                  retry_cnt <= '0;
                  state     <= STOP;
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                  bit_idx  <= 3'd7;
                  state    <= BIT;
                end
              end
              STOP: if (phase == 2'd3) state <= GAP;
              // A NACKed attempt stretches GAP so every attempt fills the same 120-quarter slot.
              GAP: if (txn_q == TXN_LAST) begin
                txn_q   <= 7'd0;
                phase   <= 2'd0;
                nacked  <= 1'b0;
                give_up <= 1'b0;
                if (give_up) begin
                  state <= ERROR;
                  busy  <= 1'b0;
                  error <= 1'b1;
                end else if (nacked) begin
                  state <= START;
                end else if (entry_idx == 4'd10) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  entry_idx <= entry_idx + 1'b1;
                  state     <= START;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_config_seq.sv
// Bench for wm8731_config_seq: an I2C slave/monitor decodes the bus and the
// expected byte stream, latency and final flags come from the register table.
module tb_wm8731_config_seq;

  localparam int Q     = 4;
  localparam int MAXR  = 3;
  localparam int TXN   = 120 * Q;
  localparam int LIMIT = 20000;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       sdat_in, sdat_oe, sclk, busy, done, error;
  logic [3:0] entry_idx;
  logic       slave_drv = 1'b0;

  int checks = 0;
  int errors = 0;

  int reg_addr[11] = '{'h0F, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09};
  int reg_data[11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h042, 'h000, 'h001};

  // Slave/monitor state, owned by the monitor process.
  logic       prev_scl = 1'b1, prev_sda = 1'b1, sda_now, in_ack = 1'b0, nacked_txn = 1'b0;
  logic [7:0] shreg = 8'h00;
  int bitcnt = 0, bytes_in_txn = 0, completed = 0, nacks_given = 0;
  int starts = 0, stops = 0, proto_err = 0;
  int obs_q[$];

  // Slave control, owned by the main process.
  int nack_target = -1, nack_limit = 0;
  int base_idx, start_base, stop_base, perr_base;
  int cyc;
  bit aborted;

  assign sdat_in = ~(sdat_oe | slave_drv);

  always #5 clk = ~clk;

  wm8731_config_seq #(.QUARTER(Q), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .start(start), .sdat_in(sdat_in),
    .sdat_oe(sdat_oe), .sclk(sclk), .busy(busy), .done(done),
    .error(error), .entry_idx(entry_idx)
  );

  // I2C slave and protocol monitor sampled away from the active edge.
  always @(negedge clk) begin
    sda_now = sdat_in;
    if (reset) begin
      bitcnt = 0; in_ack = 1'b0; slave_drv = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (prev_scl && sclk && (sda_now !== prev_sda)) begin
        if (!sda_now) begin
          if (bitcnt != 0 || in_ack) proto_err++;
          starts++; bytes_in_txn = 0; nacked_txn = 1'b0;
        end else begin
          if (bitcnt > 1 || in_ack || bytes_in_txn == 0) proto_err++;
          stops++;
          if (!nacked_txn && bytes_in_txn == 3) completed++;
        end
        bitcnt = 0;
      end else if (!prev_scl && sclk) begin
        if (in_ack) begin
          if (sdat_oe !== 1'b0) proto_err++;
        end else begin
          shreg = {shreg[6:0], sda_now};
          bitcnt++;
          if (bitcnt == 8) begin
            obs_q.push_back(int'(shreg));
            bytes_in_txn++;
          end
        end
      end else if (prev_scl && !sclk) begin
        if (in_ack) begin
          in_ack = 1'b0; slave_drv = 1'b0; bitcnt = 0;
        end else if (bitcnt == 8) begin
          in_ack = 1'b1;
          if (bytes_in_txn == 1 && completed == nack_target && nacks_given < nack_limit) begin
            nacks_given++; nacked_txn = 1'b1; slave_drv = 1'b0;
          end else begin
            slave_drv = 1'b1;
          end
        end
      end
      prev_scl = sclk;
      prev_sda = sda_now;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Run one configuration pass; optionally re-pulse start or assert reset at a given cycle.
  task automatic applyStimulus(input int n_entry, input int n_nack, input int extra_at,
                               input int rst_at, output int run_cyc, output bit run_aborted);
    nack_target = (n_entry < 0) ? -1 : completed + n_entry;
    nack_limit  = nacks_given + n_nack;
    base_idx    = obs_q.size();
    start_base  = starts;
    stop_base   = stops;
    perr_base   = proto_err;
    run_aborted = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_cyc = 0;
    while (!done && !error && run_cyc < LIMIT) begin
      @(negedge clk);
      run_cyc++;
      start = (run_cyc == extra_at);
      if (run_cyc == rst_at) begin
        #1 reset = 1'b1;
        #1 run_aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Reference: table order, each NACKed address attempt sends only 0x34, every attempt is 120 quarters.
  task automatic checkRun(input string tag, input int n_entry, input int n_nack, input int run_cyc);
    int exp_q[$];
    int attempts = 0;
    bit fail = 1'b0;
    int last = 10;
    int w;
    for (int e = 0; e < 11; e++) begin
      if (e == n_entry) begin
        int k = (n_nack > MAXR) ? MAXR + 1 : n_nack;
        fail = (n_nack > MAXR);
        for (int j = 0; j < k; j++) begin
          exp_q.push_back('h34);
          attempts++;
        end
        if (fail) begin
          last = e;
          break;
        end
      end
      w = (reg_addr[e] << 9) | reg_data[e];
      exp_q.push_back('h34);
      exp_q.push_back((w >> 8) & 'hFF);
      exp_q.push_back(w & 'hFF);
      attempts++;
    end
    checkRange({tag, "_latency"}, run_cyc, attempts * TXN - 2, attempts * TXN + 2);
    checkOutput({tag, "_done"}, done, fail ? 0 : 1);
    checkOutput({tag, "_error"}, error, fail ? 1 : 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_entry_idx"}, entry_idx, last);
    checkOutput({tag, "_sclk"}, sclk, 1);
    checkOutput({tag, "_sdat_oe"}, sdat_oe, 0);
    checkOutput({tag, "_nbytes"}, obs_q.size() - base_idx, exp_q.size());
    for (int i = 0; i < exp_q.size() && base_idx + i < obs_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), obs_q[base_idx + i], exp_q[i]);
    checkOutput({tag, "_starts"}, starts - start_base, attempts);
    checkOutput({tag, "_stops"}, stops - stop_base, attempts);
    checkOutput({tag, "_protocol"}, proto_err - perr_base, 0);
    repeat (10) @(negedge clk);
    checkOutput({tag, "_flag_hold"}, {done, error}, fail ? 2'b01 : 2'b10);
  endtask

  initial begin
    int r_entry, r_nack, extra, rst_cyc;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sclk", sclk, 1);
    checkOutput("reset_sdat_oe", sdat_oe, 0);
    checkOutput("reset_flags", {busy, done, error}, 0);
    checkOutput("reset_entry_idx", entry_idx, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] all-ACK configuration pass");
    applyStimulus(-1, 0, -1, -1, cyc, aborted);
    checkRun("allack", -1, 0, cyc);

    $display("[TB] entry 3 NACKed twice");
    applyStimulus(3, 2, -1, -1, cyc, aborted);
    checkRun("nack3", 3, 2, cyc);

    r_entry = $urandom_range(0, 10);
    r_nack  = $urandom_range(1, MAXR);
    $display("[TB] random NACK run: entry %0d nacks %0d", r_entry, r_nack);
    applyStimulus(r_entry, r_nack, -1, -1, cyc, aborted);
    checkRun("nackrand", r_entry, r_nack, cyc);

    extra = $urandom_range(2 * TXN + 1, 3 * TXN - 10);
    $display("[TB] second start pulse at cycle %0d", extra);
    applyStimulus(-1, 0, extra, -1, cyc, aborted);
    checkRun("restart_ignored", -1, 0, cyc);

    $display("[TB] entry 5 always NACKed");
    applyStimulus(5, 100, -1, -1, cyc, aborted);
    checkRun("giveup5", 5, 100, cyc);

    rst_cyc = 4 * TXN + $urandom_range(310, 440);
    $display("[TB] reset during entry 4 data byte at cycle %0d", rst_cyc);
    applyStimulus(-1, 0, -1, rst_cyc, cyc, aborted);
    checkOutput("midreset_taken", aborted, 1);
    checkOutput("midreset_sclk", sclk, 1);
    checkOutput("midreset_sdat_oe", sdat_oe, 0);
    checkOutput("midreset_flags", {busy, done, error}, 0);
    checkOutput("midreset_entry_idx", entry_idx, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(-1, 0, -1, -1, cyc, aborted);
    checkRun("after_reset", -1, 0, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
